// File: rtl/my_div_unit_if.sv
// ---------------------------------------------------------------------------
// my_div_unit_if
// Groups the issue-side request and the RF write-back response of the
// iterative divider.
//   master : issuing pipeline (drives start/op/src1/src2/wr_in/flush)
//   slave  : divider (drives busy/done/result/wr_out/we_out)
//
// Handshake: start is sampled only while busy=0. A request is accepted at
// the rising edge where start=1, flush=0 and the unit is idle. result, wr_out
// and we_out are meaningful only while done=1. done pulses for one cycle.
// flush aborts an accepted operation, and no done pulse follows.
// ---------------------------------------------------------------------------
interface my_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [4:0]       wr_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       wr_out;
  logic             we_out;

  modport master (
    output start, op, src1, src2, wr_in, flush,
    input  busy, done, result, wr_out, we_out
  );

  modport slave (
    input  start, op, src1, src2, wr_in, flush,
    output busy, done, result, wr_out, we_out
  );
endinterface

// File: rtl/my_div_unit.sv
// ---------------------------------------------------------------------------
// my_div_unit
// Iterative restoring divider for DIV.W / MOD.W / DIV.WU / MOD.WU.
// It runs WIDTH shift/subtract steps on magnitudes, then uses one further
// edge to apply the sign fix-up and the divide-by-zero override. The result
// appears WIDTH+1 edges after the accepting edge, whatever the operands.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   div_if       slave modport of my_div_unit_if (request / write-back)
//   o_dbg_state  out  current FSM state (0 IDLE, 1 CALC, 2 DONE)
// ---------------------------------------------------------------------------
module my_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  my_div_unit_if.slave  div_if,
  output logic [1:0]    o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_next;

  logic             r_is_mod;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz;
  logic [WIDTH-1:0] r_src1;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_wr_lat;
  logic [4:0]       r_wr_out;

  logic             w_accept;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic             w_last_step;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // flush wins over start, so a request killed in the same cycle is dropped.
  assign w_accept = (r_state == S_IDLE) && div_if.start && !div_if.flush;

  // Only op[1]=0 (DIV.W / MOD.W) treats the operands as two's complement.
  assign w_signed = ~div_if.op[1];
  assign w_abs1   = (w_signed && div_if.src1[WIDTH-1]) ? -div_if.src1 : div_if.src1;
  assign w_abs2   = (w_signed && div_if.src2[WIDTH-1]) ? -div_if.src2 : div_if.src2;

  // r_count reaches WIDTH after the last restoring step. The edge taken with
  // r_count==WIDTH does the fix-up and enters DONE.
  assign w_last_step = (r_count == CW'(WIDTH));

  // One restoring step. The shifted remainder needs WIDTH+1 bits, because an
  // unsigned divisor with its MSB set can exceed a WIDTH-bit shifted value.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  // Sign fix-up and the divide-by-zero override. The negation wraps, so
  // 0x80000000 / -1 gives 0x80000000.
  assign w_quo_fix = r_dvz ? '1     : (r_neg_q ? -r_quo : r_quo);
  assign w_rem_fix = r_dvz ? r_src1 : (r_neg_r ? -r_rem : r_rem);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (div_if.flush)     w_next = S_IDLE;
        else if (w_last_step) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_mod <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
      r_src1   <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_wr_lat <= '0;
      r_wr_out <= '0;
    end else begin
      if (w_accept) begin
        r_is_mod <= div_if.op[0];
        r_neg_q  <= w_signed && (div_if.src1[WIDTH-1] ^ div_if.src2[WIDTH-1]);
        r_neg_r  <= w_signed && div_if.src1[WIDTH-1];
        r_dvz    <= (div_if.src2 == '0);
        r_src1   <= div_if.src1;
        r_dvs    <= w_abs2;
        r_rem    <= '0;
        r_quo    <= w_abs1;
        r_count  <= '0;
        r_wr_lat <= div_if.wr_in;
      end else if (r_state == S_CALC && !div_if.flush) begin
        if (!w_last_step) begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + CW'(1);
        end else begin
          // The result and destination tag change only when a result is
          // produced. They hold their values in all other cycles.
          r_result <= r_is_mod ? w_rem_fix : w_quo_fix;
          r_wr_out <= r_wr_lat;
        end
      end
    end
  end

  assign div_if.busy   = (r_state != S_IDLE);
  // A flush in DONE suppresses the pulse in that same cycle.
  assign div_if.done   = (r_state == S_DONE) && !div_if.flush;
  assign div_if.result = r_result;
  assign div_if.wr_out = r_wr_out;
  assign div_if.we_out = div_if.done && (r_wr_out != 5'd0);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_my_div_unit.sv
// ---------------------------------------------------------------------------
// tb_my_div_unit
// Directed test of my_div_unit. The expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_my_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MOD  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_MODU = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  my_div_unit_if #(.WIDTH(W)) dif ();

  my_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_if      (dif),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. It returns just after the edge that samples start.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] wr);
    dif.op    = op;
    dif.src1  = a;
    dif.src2  = b;
    dif.wr_in = wr;
    dif.start = 1'b1;
    @(posedge clk);
    #1 dif.start = 1'b0;
  endtask

  // This counts edges after the sampling edge until done is seen at a negedge.
  // The wait is bounded.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (dif.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (dif.done) cnt++;
    end
  endtask

  // One full operation. It starts at a negedge and ends at a negedge with the
  // unit back in IDLE, so consecutive calls issue back to back.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] wr, input logic [W-1:0] exp);
    int       lat;
    bit       seen;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    start_op(op, a, b, wr);
    wait_done(lat, seen);
    e = exp_q.pop_front();
    check({tag, "_done"}, W'(seen), W'(1));
    check({tag, "_lat"}, W'(lat), W'(33));
    if (seen) begin
      check({tag, "_result"}, dif.result, e);
      check({tag, "_we"}, W'(dif.we_out), W'(wr != 5'd0));
      check({tag, "_wr"}, W'(dif.wr_out), W'(wr));
      check({tag, "_busy_done"}, W'(dif.busy), W'(1));
    end
    @(negedge clk);
    check({tag, "_idle_busy"}, W'(dif.busy), W'(0));
    check({tag, "_idle_done"}, W'(dif.done), W'(0));
    check({tag, "_hold"}, dif.result, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int lat;
    logic [W-1:0] got;

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.op    = 2'b00;
    dif.src1  = '0;
    dif.src2  = '0;
    dif.wr_in = 5'd0;
    dif.flush = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy",   W'(dif.busy),   W'(0));
    check("rst_done",   W'(dif.done),   W'(0));
    check("rst_result", dif.result,     W'(0));
    check("rst_wr",     W'(dif.wr_out), W'(0));
    check("rst_we",     W'(dif.we_out), W'(0));
    check("rst_state",  W'(dbg_state),  W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // basic signed divide and sign handling
    do_op("div_100_7",   OP_DIV,  32'd100,        32'd7,          5'd5,  32'd14);
    do_op("mod_m7_2",    OP_MOD,  32'hFFFFFFF9,   32'd2,          5'd9,  32'hFFFFFFFF);
    do_op("div_m7_2",    OP_DIV,  32'hFFFFFFF9,   32'd2,          5'd0,  32'hFFFFFFFD);
    do_op("mod_7_m2",    OP_MOD,  32'd7,          32'hFFFFFFFE,   5'd1,  32'd1);
    // overflow corner and unsigned interpretation of the same bits
    do_op("div_ovf",     OP_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd2,  32'h80000000);
    do_op("mod_ovf",     OP_MOD,  32'h80000000,   32'hFFFFFFFF,   5'd2,  32'd0);
    do_op("divu_ovf",    OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd3,  32'd0);
    do_op("modu_big",    OP_MODU, 32'hFFFFFFFF,   32'h80000001,   5'd4,  32'h7FFFFFFE);
    // divide by zero
    do_op("divu_z",      OP_DIVU, 32'h00001234,   32'd0,          5'd6,  32'hFFFFFFFF);
    do_op("modu_z",      OP_MODU, 32'h00001234,   32'd0,          5'd7,  32'h00001234);
    do_op("div_z_neg",   OP_DIV,  32'hFFFFFFFB,   32'd0,          5'd8,  32'hFFFFFFFF);
    do_op("mod_z_neg",   OP_MOD,  32'hFFFFFFFB,   32'd0,          5'd8,  32'hFFFFFFFB);

    // A start while busy is ignored. Only the first operation completes.
    start_op(OP_DIV, 32'd1000, 32'd10, 5'd11);
    cnt = 0;
    lat = 0;
    got = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (dif.done) begin
        cnt++;
        lat = c;
        got = dif.result;
      end
      if (c == 10) begin
        dif.op    = OP_MOD;
        dif.src1  = 32'd77;
        dif.src2  = 32'd5;
        dif.wr_in = 5'd12;
        dif.start = 1'b1;
      end else begin
        dif.start = 1'b0;
      end
    end
    check("ign_count",  W'(cnt), W'(1));
    check("ign_lat",    W'(lat), W'(33));
    check("ign_result", got,     W'(100));
    check("ign_wr",     W'(dif.wr_out), W'(11));

    // The next two operations issue back to back, right after the previous done.
    do_op("b2b_a",       OP_DIVU, 32'd50,         32'd6,          5'd13, 32'd8);
    do_op("b2b_b",       OP_MODU, 32'd50,         32'd6,          5'd14, 32'd2);

    // flush sampled at edge 15 of the operation
    start_op(OP_DIV, 32'd500, 32'd5, 5'd15);
    repeat (13) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    check("flush_done_same", W'(dif.done), W'(0));
    @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush_busy",  W'(dif.busy),  W'(0));
    check("flush_state", W'(dbg_state), W'(0));
    count_dones(40, cnt);
    check("flush_no_done", W'(cnt), W'(0));
    check("flush_hold",    dif.result, W'(2));

    // Reset asserted at cycle 20 of an operation clears the outputs at once.
    start_op(OP_DIVU, 32'd900, 32'd9, 5'd16);
    repeat (19) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   W'(dif.busy),   W'(0));
    check("arst_done",   W'(dif.done),   W'(0));
    check("arst_result", dif.result,     W'(0));
    check("arst_wr",     W'(dif.wr_out), W'(0));
    check("arst_we",     W'(dif.we_out), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, cnt);
    check("arst_no_done", W'(cnt), W'(0));

    // The unit works normally after the reset.
    do_op("post_rst",    OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd31, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
